adc_responder: RTL and testbench

//  Synthesisable responder for the LTC1407A-style dual-channel ADC serial port: the device end of the

---
 rtl/adc_responder.sv | 113 +++++++++++
 tb/tb_adc_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_responder.sv
// Device end of an LTC1407A-style dual-channel ADC serial link: a conv rising edge latches
// both samples, then one 34-bit frame bit is shifted out per spi_sck falling edge.
module adc_responder #(
  parameter int DATA_W = 14,
  parameter int Z_BITS = 2
) (
  input  logic              CLK50MHZ,
  input  logic              RST,
  input  logic              spi_sck,
  input  logic              adc_conv,
  output logic              adc_out,
  output logic              adc_out_oe,
  input  logic [DATA_W-1:0] sample_a,
  input  logic [DATA_W-1:0] sample_b,
  output logic              sample_latch,
  output logic              busy,
  output logic              frame_done
);

  localparam int FRAME_W = 2*DATA_W + 3*Z_BITS;
  localparam int K_W     = $clog2(FRAME_W);
  localparam logic [K_W-1:0] K_LAST = K_W'(FRAME_W - 1);
  localparam logic [FRAME_W-1:0] OE_MASK =
    {{Z_BITS{1'b0}}, {DATA_W{1'b1}}, {Z_BITS{1'b0}}, {DATA_W{1'b1}}, {Z_BITS{1'b0}}};

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic [FRAME_W-1:0] oe_sr_q, oe_sr_d;
  logic               out_q, out_d;
  logic               oe_q, oe_d;
  logic               latch_q, latch_d;
  logic               done_q, done_d;
  logic               conv_q, sck_q;

  logic               conv_rise, sck_fall;
  logic [FRAME_W-1:0] frame_new;

  assign conv_rise = adc_conv & ~conv_q;
  assign sck_fall  = sck_q & ~spi_sck;
  assign frame_new = {{Z_BITS{1'b0}}, sample_a, {Z_BITS{1'b0}}, sample_b, {Z_BITS{1'b0}}};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    oe_sr_d = oe_sr_q;
    out_d   = out_q;
    oe_d    = oe_q;
    latch_d = 1'b0;
    done_d  = 1'b0;
    // A new conversion always wins, even over the final falling edge of a frame.
    if (conv_rise) begin
      state_d = ST_SHIFT;
      k_d     = '0;
      out_d   = frame_new[FRAME_W-1] & OE_MASK[FRAME_W-1];
      oe_d    = OE_MASK[FRAME_W-1];
      data_d  = {frame_new[FRAME_W-2:0], 1'b0};
      oe_sr_d = {OE_MASK[FRAME_W-2:0], 1'b0};
      latch_d = 1'b1;
    end else if (state_q == ST_SHIFT && sck_fall) begin
      if (k_q == K_LAST) begin
        state_d = ST_IDLE;
        k_d     = '0;
        out_d   = 1'b0;
        oe_d    = 1'b0;
        done_d  = 1'b1;
      end else begin
        k_d     = k_q + 1'b1;
        out_d   = data_q[FRAME_W-1] & oe_sr_q[FRAME_W-1];
        oe_d    = oe_sr_q[FRAME_W-1];
        data_d  = {data_q[FRAME_W-2:0], 1'b0};
        oe_sr_d = {oe_sr_q[FRAME_W-2:0], 1'b0};
      end
    end
  end

  // sck_q resets high so a low sck at release is not taken as a falling edge.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      data_q  <= '0;
      oe_sr_q <= '0;
      out_q   <= 1'b0;
      oe_q    <= 1'b0;
      latch_q <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      sck_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
      oe_sr_q <= oe_sr_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      latch_q <= latch_d;
      done_q  <= done_d;
      conv_q  <= adc_conv;
      sck_q   <= spi_sck;
    end
  end

  assign adc_out      = out_q;
  assign adc_out_oe   = oe_q;
  assign sample_latch = latch_q;
  assign busy         = (state_q == ST_SHIFT);
  assign frame_done   = done_q;

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench for adc_responder: stimulus queues the expected bit per sck fall,
// a negedge monitor pops and compares, and tracks latch/done/busy pulse timing.
module tb_adc_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sck = 1'b1;
  logic        adc_conv = 1'b0;
  logic [13:0] sample_a = '0;
  logic [13:0] sample_b = '0;
  logic        adc_out, adc_out_oe, sample_latch, busy, frame_done;

  adc_responder dut (
    .CLK50MHZ    (clk),
    .RST         (rst_n),
    .spi_sck     (spi_sck),
    .adc_conv    (adc_conv),
    .adc_out     (adc_out),
    .adc_out_oe  (adc_out_oe),
    .sample_a    (sample_a),
    .sample_b    (sample_b),
    .sample_latch(sample_latch),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic        out;
    logic        oe;
    logic        last;
    logic [33:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Hand-computed frames: {00, A, 00, B, 00} and the oe pattern.
  logic [33:0] oe_w     = 34'h0FFFCFFFC;
  logic [33:0] w_2aaa   = 34'h0AAA85554;
  logic [33:0] w_ext    = 34'h080007FFC;
  logic [33:0] w_rst    = 34'h00004FFFC;

  // Monitor
  logic        sck_prev = 1'b1, conv_prev = 1'b0;
  logic        nx_latch = 1'b0, nx_done = 1'b0, exp_busy = 1'b0;
  logic [33:0] cap = '0;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outs", {59'd0, adc_out, adc_out_oe, sample_latch, busy, frame_done}, 64'd0);
      nx_latch = 1'b0;
      nx_done  = 1'b0;
      exp_busy = 1'b0;
    end else begin
      check("sample_latch", {63'd0, sample_latch}, {63'd0, nx_latch});
      check("frame_done", {63'd0, frame_done}, {63'd0, nx_done});
      check("busy", {63'd0, busy}, {63'd0, exp_busy});
      if (nx_latch)
        check("bit0_out_oe", {62'd0, adc_out, adc_out_oe}, 64'd0);
      nx_latch = 1'b0;
      nx_done  = 1'b0;
      if (sck_prev && !spi_sck) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("adc_out", {63'd0, adc_out}, {63'd0, e.out});
          check("adc_out_oe", {63'd0, adc_out_oe}, {63'd0, e.oe});
          cap = {cap[32:0], adc_out};
          if (e.last) begin
            check("frame_word", {30'd0, cap}, {30'd0, e.word});
            nx_done  = 1'b1;
            exp_busy = 1'b0;
          end
        end
      end
      if (adc_conv && !conv_prev) begin
        nx_latch = 1'b1;
        nx_done  = 1'b0;
        exp_busy = 1'b1;
      end
    end
    sck_prev  = spi_sck;
    conv_prev = adc_conv;
  end

  // Stimulus-side frame model
  bit          m_busy = 1'b0;
  int          m_k = 0;
  logic [33:0] m_word = '0;

  task automatic push_fall(input bit conv_too);
    exp_t x;
    x.out  = m_busy ? m_word[33-m_k] : 1'b0;
    x.oe   = m_busy ? oe_w[33-m_k] : 1'b0;
    x.last = m_busy && (m_k == 33) && !conv_too;
    x.word = m_word;
    exp_q.push_back(x);
    if (m_busy) begin
      if (m_k == 33) m_busy = 1'b0;
      else m_k++;
    end
  endtask

  task automatic fall();
    @(posedge clk); #1;
    push_fall(1'b0);
    spi_sck = 1'b0;
    repeat (2) @(posedge clk);
    #1 spi_sck = 1'b1;
    @(posedge clk);
  endtask

  task automatic falls(input int n);
    for (int i = 0; i < n; i++) fall();
  endtask

  task automatic conv(input logic [13:0] a, input logic [13:0] b, input logic [33:0] w,
                      input int width);
    @(posedge clk); #1;
    sample_a = a;
    sample_b = b;
    adc_conv = 1'b1;
    m_busy = 1'b1; m_k = 0; m_word = w;
    repeat (width) @(posedge clk);
    #1 adc_conv = 1'b0;
  endtask

  task automatic conv_with_fall(input logic [13:0] a, input logic [13:0] b, input logic [33:0] w);
    @(posedge clk); #1;
    push_fall(1'b1);
    sample_a = a;
    sample_b = b;
    adc_conv = 1'b1;
    spi_sck  = 1'b0;
    m_busy = 1'b1; m_k = 0; m_word = w;
    @(posedge clk); #1 adc_conv = 1'b0;
    @(posedge clk); #1 spi_sck = 1'b1;
    @(posedge clk);
  endtask

  task automatic gap();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    // Reset held with activity on the inputs
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      spi_sck  = ~spi_sck;
      adc_conv = (i % 3 == 1);
    end
    @(posedge clk); #1;
    spi_sck = 1'b1; adc_conv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Single frame, alternating pattern
    conv(14'h2AAA, 14'h1555, w_2aaa, 1);
    falls(34);
    gap();

    // Falls with no conversion are ignored
    falls(3);
    gap();

    // Extremes, conv held high, samples changed after latch
    conv(14'h2000, 14'h1FFF, w_ext, 5);
    sample_a = 14'h0F0F; sample_b = 14'h3333;
    falls(34);
    gap();

    // Restart after 20 falls
    conv(14'h2AAA, 14'h1555, w_2aaa, 1);
    falls(20);
    conv(14'h0001, 14'h3FFF, w_rst, 1);
    falls(34);
    gap();

    // Restart coincident with the 34th fall
    conv(14'h2000, 14'h1FFF, w_ext, 1);
    falls(33);
    conv_with_fall(14'h0001, 14'h3FFF, w_rst);
    falls(34);
    gap();

    // Reset mid-frame at k=10
    conv(14'h2AAA, 14'h1555, w_2aaa, 1);
    falls(10);
    @(posedge clk); #1 rst_n = 1'b0;
    m_busy = 1'b0; m_k = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    gap();
    falls(4);
    gap();
    conv(14'h0001, 14'h3FFF, w_rst, 1);
    falls(34);
    gap();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
